// File: rtl/operand_stage_if.sv
// ---------------------------------------------------------------------------
// operand_stage_if
//   Bundles the signals the operand stage exchanges with the rest of the
//   pipeline. The register clock and reset stay outside as plain ports.
//
//   ID side        : flush, id_valid, id_rs1/rs2/rd, id_rdata1/2,
//                    id_reg_write, id_mem_read
//   Forward paths  : ex_alu_result, mem_rd/reg_write/result,
//                    wb_rd/reg_write/result
//   Stage outputs  : stall (combinational), ex_valid, ex_rd, ex_reg_write,
//                    ex_mem_read, ex_op1, ex_op2, stall_count (registered)
//
//   master : the pipeline around the stage (drives ID and forward paths)
//   slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface operand_stage_if #(
   parameter int DATA_W = 64
);
   // ID-stage instruction and register-file read data
   logic              flush;
   logic              id_valid;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic [4:0]        id_rd;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic              id_reg_write;
   logic              id_mem_read;

   // Forwarding sources from the downstream stages
   logic [DATA_W-1:0] ex_alu_result;
   logic [4:0]        mem_rd;
   logic              mem_reg_write;
   logic [DATA_W-1:0] mem_result;
   logic [4:0]        wb_rd;
   logic              wb_reg_write;
   logic [DATA_W-1:0] wb_result;

   // Stage outputs
   logic              stall;
   logic              ex_valid;
   logic [4:0]        ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic [DATA_W-1:0] ex_op1;
   logic [DATA_W-1:0] ex_op2;
   logic [15:0]       stall_count;

   modport master (
      output flush, id_valid, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
             id_reg_write, id_mem_read,
             ex_alu_result, mem_rd, mem_reg_write, mem_result,
             wb_rd, wb_reg_write, wb_result,
      input  stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
             ex_op1, ex_op2, stall_count
   );

   modport slave (
      input  flush, id_valid, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2,
             id_reg_write, id_mem_read,
             ex_alu_result, mem_rd, mem_reg_write, mem_result,
             wb_rd, wb_reg_write, wb_result,
      output stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
             ex_op1, ex_op2, stall_count
   );
endinterface

// File: rtl/operand_stage.sv
// ---------------------------------------------------------------------------
// operand_stage
//   ID/EX boundary of an in-order pipeline. Resolves both source operands of
//   the instruction in ID (X31 reads as zero, then EX > MEM > WB forwarding,
//   then register-file data), detects load-use hazards and registers the
//   resolved instruction into the EX-side outputs one cycle later.
//
//   Ports
//     clk    : single clock, all state changes on the rising edge
//     reset  : synchronous, active low
//     bus    : operand_stage_if.slave (ID inputs, forward paths, EX outputs)
//
//   Hazard handling
//     A load in EX whose destination is read by the instruction in ID cannot
//     be forwarded (data is not back yet). stall is raised for one cycle, the
//     upstream holds ID, and a bubble enters EX. Next cycle the load sits in
//     MEM and the operand is picked up from mem_result.
//     flush kills the ID instruction and always wins over stall.
// ---------------------------------------------------------------------------
module operand_stage #(
   parameter int DATA_W = 64
) (
   input logic            clk,
   input logic            reset,
   operand_stage_if.slave bus
);

   // X31 is the hard-wired zero register: never forwarded, never a hazard.
   localparam logic [4:0]  ZERO_REG  = 5'd31;
   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   // ------------------------------------------------------------------------
   // EX-side state
   // ------------------------------------------------------------------------
   logic              ex_valid_q;
   logic [4:0]        ex_rd_q;
   logic              ex_reg_write_q;
   logic              ex_mem_read_q;
   logic [DATA_W-1:0] ex_op1_q;
   logic [DATA_W-1:0] ex_op2_q;
   logic [15:0]       stall_count_q;

   // ------------------------------------------------------------------------
   // Forwarding
   // ------------------------------------------------------------------------
   // The EX instruction only writes back if it is real; a bubble may still
   // carry a stale rd that must not be matched.
   logic ex_wen;
   assign ex_wen = ex_valid_q & ex_reg_write_q;

   function automatic logic stage_hit(
      input logic       wen,
      input logic [4:0] rd,
      input logic [4:0] rs
   );
      return wen && (rd == rs) && (rs != ZERO_REG);
   endfunction

   // Priority chain: zero register, youngest producer first, then regfile.
   // WB forwarding also provides the write-then-read bypass for a register
   // file that is written in the same cycle it is read.
   function automatic logic [DATA_W-1:0] select_operand(
      input logic [4:0]        rs,
      input logic [DATA_W-1:0] rdata,
      input logic              ex_w,
      input logic [4:0]        ex_d,
      input logic [DATA_W-1:0] ex_res,
      input logic              mem_w,
      input logic [4:0]        mem_d,
      input logic [DATA_W-1:0] mem_res,
      input logic              wb_w,
      input logic [4:0]        wb_d,
      input logic [DATA_W-1:0] wb_res
   );
      if (rs == ZERO_REG)                 return '0;
      else if (stage_hit(ex_w, ex_d, rs))   return ex_res;
      else if (stage_hit(mem_w, mem_d, rs)) return mem_res;
      else if (stage_hit(wb_w, wb_d, rs))   return wb_res;
      else                                  return rdata;
   endfunction

   logic [DATA_W-1:0] op1_sel;
   logic [DATA_W-1:0] op2_sel;

   always_comb begin
      op1_sel = select_operand(bus.id_rs1, bus.id_rdata1,
                               ex_wen, ex_rd_q, bus.ex_alu_result,
                               bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                               bus.wb_reg_write, bus.wb_rd, bus.wb_result);
      op2_sel = select_operand(bus.id_rs2, bus.id_rdata2,
                               ex_wen, ex_rd_q, bus.ex_alu_result,
                               bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                               bus.wb_reg_write, bus.wb_rd, bus.wb_result);
   end

   // ------------------------------------------------------------------------
   // Load-use hazard detection
   // ------------------------------------------------------------------------
   logic ex_is_load;
   logic rs_uses_load;
   logic stall;

   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here by
      // straight-line assignment) so no latch can be inferred.
      ex_is_load   = ex_valid_q & ex_mem_read_q & ex_reg_write_q &
                     (ex_rd_q != ZERO_REG);
      rs_uses_load = (ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2);
      stall        = bus.id_valid & ex_is_load & rs_uses_load & ~bus.flush;
   end

   // A bubble goes into EX on a stall or a flush; operands and rd hold.
   logic bubble;
   assign bubble = stall | bus.flush;

   // ------------------------------------------------------------------------
   // ID -> EX register
   // ------------------------------------------------------------------------
   // NOTE: all state here is flops, assigned with non-blocking (<=) so every
   // register samples the pre-edge values; each is cleared by reset since
   // downstream logic reads ex_op*/ex_rd even for bubbles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_op1_q       <= '0;
         ex_op2_q       <= '0;
      end else if (bubble) begin
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
      end else begin
         ex_valid_q     <= bus.id_valid;
         ex_rd_q        <= bus.id_rd;
         ex_reg_write_q <= bus.id_reg_write & bus.id_valid;
         ex_mem_read_q  <= bus.id_mem_read & bus.id_valid;
         ex_op1_q       <= op1_sel;
         ex_op2_q       <= op2_sel;
      end
   end

   // ------------------------------------------------------------------------
   // Stall statistics: saturating so long runs read as "at least 0xFFFF".
   // stall already excludes flushed cycles.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_count_q <= '0;
      end else if (stall && (stall_count_q != COUNT_MAX)) begin
         stall_count_q <= stall_count_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.stall        = stall;
   assign bus.ex_valid     = ex_valid_q;
   assign bus.ex_rd        = ex_rd_q;
   assign bus.ex_reg_write = ex_reg_write_q;
   assign bus.ex_mem_read  = ex_mem_read_q;
   assign bus.ex_op1       = ex_op1_q;
   assign bus.ex_op2       = ex_op2_q;
   assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_stage
//   Directed bench for operand_stage. A table of one-cycle vectors covers
//   forwarding priority, the zero register, load-use stall and flush; short
//   hand-written sequences cover reset and stall_count saturation.
//   Inputs change on the falling edge; stall is sampled before the rising
//   edge, registered outputs 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_operand_stage;

   localparam int DATA_W = 64;

   logic clk;
   logic reset;

   operand_stage_if #(.DATA_W(DATA_W)) bus ();

   operand_stage #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      // inputs
      logic              flush;
      logic              id_valid;
      logic [4:0]        rs1, rs2, rd;
      logic [DATA_W-1:0] rdata1, rdata2;
      logic              rw, mr;
      logic [DATA_W-1:0] ex_alu;
      logic [4:0]        mem_rd;
      logic              mem_rw;
      logic [DATA_W-1:0] mem_res;
      logic [4:0]        wb_rd;
      logic              wb_rw;
      logic [DATA_W-1:0] wb_res;
      // expected
      logic              e_stall, e_valid;
      logic [4:0]        e_rd;
      logic              e_rw, e_mr;
      logic [DATA_W-1:0] e_op1, e_op2;
      logic [15:0]       e_cnt;
   } vec_t;

   localparam int NVEC = 15;
   vec_t tv[NVEC];

   function automatic vec_t mk_id(input logic fl, vld, input logic [4:0] rs1, rs2, rd,
                                  input logic [63:0] d1, d2, input logic rw, mr);
      vec_t v;
      v = '{default: '0};
      v.flush = fl; v.id_valid = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.rdata1 = d1; v.rdata2 = d2; v.rw = rw; v.mr = mr;
      return v;
   endfunction

   function automatic vec_t with_fwd(input vec_t v, input logic [63:0] ex_alu,
                                     input logic [4:0] mrd, input logic mrw, input logic [63:0] mres,
                                     input logic [4:0] wrd, input logic wrw, input logic [63:0] wres);
      vec_t r = v;
      r.ex_alu = ex_alu; r.mem_rd = mrd; r.mem_rw = mrw; r.mem_res = mres;
      r.wb_rd = wrd; r.wb_rw = wrw; r.wb_res = wres;
      return r;
   endfunction

   function automatic vec_t with_exp(input vec_t v, input logic st, vl, input logic [4:0] rd,
                                     input logic rw, mr, input logic [63:0] o1, o2,
                                     input logic [15:0] cnt);
      vec_t r = v;
      r.e_stall = st; r.e_valid = vl; r.e_rd = rd; r.e_rw = rw; r.e_mr = mr;
      r.e_op1 = o1; r.e_op2 = o2; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic drive_idle();
      bus.flush = 0; bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rdata1 = 0; bus.id_rdata2 = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
      bus.ex_alu_result = 0; bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
      bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.flush = v.flush; bus.id_valid = v.id_valid;
      bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rd = v.rd;
      bus.id_rdata1 = v.rdata1; bus.id_rdata2 = v.rdata2;
      bus.id_reg_write = v.rw; bus.id_mem_read = v.mr;
      bus.ex_alu_result = v.ex_alu;
      bus.mem_rd = v.mem_rd; bus.mem_reg_write = v.mem_rw; bus.mem_result = v.mem_res;
      bus.wb_rd = v.wb_rd; bus.wb_reg_write = v.wb_rw; bus.wb_result = v.wb_res;
   endtask

   // ID instruction without forwarding sources
   task automatic drive_id(input logic [4:0] rs1, rs2, rd, input logic mr);
      drive_idle();
      bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_reg_write = 1; bus.id_mem_read = mr;
      bus.id_rdata1 = 64'h1111; bus.id_rdata2 = 64'h2222;
   endtask

   initial begin
      // -------------------------------------------------------------------
      // Vector table
      // -------------------------------------------------------------------
      // 0: ADD X1 <- X3,X4, plain regfile data
      tv[0]  = mk_id(0, 1, 3, 4, 1, 64'h11, 64'h22, 1, 0);
      tv[0]  = with_exp(tv[0], 0, 1, 1, 1, 0, 64'h11, 64'h22, 0);
      // 1: reads X1 (EX=5 beats MEM=7), X2 from WB
      tv[1]  = mk_id(0, 1, 1, 2, 6, 64'hAA, 64'hBB, 1, 0);
      tv[1]  = with_fwd(tv[1], 64'h5, 1, 1, 64'h7, 2, 1, 64'h99);
      tv[1]  = with_exp(tv[1], 0, 1, 6, 1, 0, 64'h5, 64'h99, 0);
      // 2: invalid ID, MEM beats WB on X2; flags gated by id_valid
      tv[2]  = mk_id(0, 0, 2, 3, 7, 64'hAA, 64'h33, 0, 1);
      tv[2]  = with_fwd(tv[2], 64'h1234, 2, 1, 64'h77, 2, 1, 64'h55);
      tv[2]  = with_exp(tv[2], 0, 0, 7, 0, 0, 64'h77, 64'h33, 0);
      // 3: EX bubble holds stale rd=7 -> must not forward; writes X31
      tv[3]  = mk_id(0, 1, 7, 5, 31, 64'h44, 64'h55, 1, 0);
      tv[3]  = with_fwd(tv[3], 64'hDEAD, 0, 0, 0, 0, 0, 0);
      tv[3]  = with_exp(tv[3], 0, 1, 31, 1, 0, 64'h44, 64'h55, 0);
      // 4: reads X31 while EX/MEM/WB all write X31 -> 0; ID is LDUR X2
      tv[4]  = mk_id(0, 1, 31, 31, 2, 64'hF1, 64'hF2, 1, 1);
      tv[4]  = with_fwd(tv[4], 64'hE0, 31, 1, 64'hE1, 31, 1, 64'hE2);
      tv[4]  = with_exp(tv[4], 0, 1, 2, 1, 1, 64'h0, 64'h0, 0);
      // 5: load-use on rs1=X2 -> stall, bubble, ops/rd hold
      tv[5]  = mk_id(0, 1, 2, 8, 10, 64'h200, 64'h800, 1, 0);
      tv[5]  = with_fwd(tv[5], 64'h1000, 0, 0, 0, 0, 0, 0);
      tv[5]  = with_exp(tv[5], 1, 0, 2, 0, 0, 64'h0, 64'h0, 1);
      // 6: load now in MEM -> operand from mem_result, no second stall
      tv[6]  = mk_id(0, 1, 2, 8, 10, 64'h200, 64'h800, 1, 0);
      tv[6]  = with_fwd(tv[6], 64'h0, 2, 1, 64'hCAFE, 0, 0, 0);
      tv[6]  = with_exp(tv[6], 0, 1, 10, 1, 0, 64'hCAFE, 64'h800, 1);
      // 7: LDUR X3
      tv[7]  = mk_id(0, 1, 1, 2, 3, 64'h10, 64'h20, 1, 1);
      tv[7]  = with_fwd(tv[7], 64'h5, 0, 0, 0, 0, 0, 0);
      tv[7]  = with_exp(tv[7], 0, 1, 3, 1, 1, 64'h10, 64'h20, 1);
      // 8: load-use on rs2 with flush -> no stall, bubble, count unchanged
      tv[8]  = mk_id(1, 1, 4, 3, 11, 64'h40, 64'h30, 1, 0);
      tv[8]  = with_fwd(tv[8], 64'h300, 0, 0, 0, 0, 0, 0);
      tv[8]  = with_exp(tv[8], 0, 0, 3, 0, 0, 64'h10, 64'h20, 1);
      // 9: MEM write disabled is ignored; WB bypass on rs2
      tv[9]  = mk_id(0, 1, 5, 6, 12, 64'h50, 64'h60, 0, 0);
      tv[9]  = with_fwd(tv[9], 64'h0, 5, 0, 64'h555, 6, 1, 64'h666);
      tv[9]  = with_exp(tv[9], 0, 1, 12, 0, 0, 64'h50, 64'h666, 1);
      // 10: LDUR X31
      tv[10] = mk_id(0, 1, 1, 1, 31, 64'h1, 64'h1, 1, 1);
      tv[10] = with_exp(tv[10], 0, 1, 31, 1, 1, 64'h1, 64'h1, 1);
      // 11: reading X31 after a load to X31 -> no hazard, zeros
      tv[11] = mk_id(0, 1, 31, 31, 13, 64'hA, 64'hB, 1, 0);
      tv[11] = with_fwd(tv[11], 64'h77, 0, 0, 0, 0, 0, 0);
      tv[11] = with_exp(tv[11], 0, 1, 13, 1, 0, 64'h0, 64'h0, 1);
      // 12: LDUR X4
      tv[12] = mk_id(0, 1, 0, 0, 4, 64'h0, 64'h0, 1, 1);
      tv[12] = with_fwd(tv[12], 64'h13, 0, 0, 0, 0, 0, 0);
      tv[12] = with_exp(tv[12], 0, 1, 4, 1, 1, 64'h0, 64'h0, 1);
      // 13: load-use on rs2 -> stall
      tv[13] = mk_id(0, 1, 9, 4, 14, 64'h90, 64'h40, 1, 0);
      tv[13] = with_fwd(tv[13], 64'h4000, 0, 0, 0, 0, 0, 0);
      tv[13] = with_exp(tv[13], 1, 0, 4, 0, 0, 64'h0, 64'h0, 2);
      // 14: rs2 resolved from MEM
      tv[14] = mk_id(0, 1, 9, 4, 14, 64'h90, 64'h40, 1, 0);
      tv[14] = with_fwd(tv[14], 64'h0, 4, 1, 64'hBEEF, 0, 0, 0);
      tv[14] = with_exp(tv[14], 0, 1, 14, 1, 0, 64'h90, 64'hBEEF, 2);

      // -------------------------------------------------------------------
      // Reset: low for 2 edges
      // -------------------------------------------------------------------
      drive_idle();
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst ex_valid", 64'(bus.ex_valid), 0);
      check("rst ex_rd", 64'(bus.ex_rd), 0);
      check("rst ex_reg_write", 64'(bus.ex_reg_write), 0);
      check("rst ex_mem_read", 64'(bus.ex_mem_read), 0);
      check("rst ex_op1", bus.ex_op1, 0);
      check("rst ex_op2", bus.ex_op2, 0);
      check("rst stall_count", 64'(bus.stall_count), 0);
      @(negedge clk);
      reset = 1;
      #1 check("idle stall", 64'(bus.stall), 0);

      // -------------------------------------------------------------------
      // Table
      // -------------------------------------------------------------------
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive_vec(tv[i]);
         #1 check($sformatf("v%0d stall", i), 64'(bus.stall), 64'(tv[i].e_stall));
         @(posedge clk);
         #1;
         check($sformatf("v%0d ex_valid", i), 64'(bus.ex_valid), 64'(tv[i].e_valid));
         check($sformatf("v%0d ex_rd", i), 64'(bus.ex_rd), 64'(tv[i].e_rd));
         check($sformatf("v%0d ex_reg_write", i), 64'(bus.ex_reg_write), 64'(tv[i].e_rw));
         check($sformatf("v%0d ex_mem_read", i), 64'(bus.ex_mem_read), 64'(tv[i].e_mr));
         check($sformatf("v%0d ex_op1", i), bus.ex_op1, tv[i].e_op1);
         check($sformatf("v%0d ex_op2", i), bus.ex_op2, tv[i].e_op2);
         check($sformatf("v%0d stall_count", i), 64'(bus.stall_count), 64'(tv[i].e_cnt));
      end

      // -------------------------------------------------------------------
      // stall_count saturation: preload 0xFFFE, then 3 load-use stalls
      // -------------------------------------------------------------------
      @(negedge clk);
      drive_idle();
      force dut.stall_count_q = 16'hFFFE;
      #1 release dut.stall_count_q;
      #1 check("preload stall_count", 64'(bus.stall_count), 64'hFFFE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_id(0, 0, 2, 1);               // LDUR X2
         #1 check($sformatf("sat%0d load stall", k), 64'(bus.stall), 0);
         @(negedge clk);
         drive_id(0, 2, 5, 0);               // reads X2 on rs2
         #1 check($sformatf("sat%0d use stall", k), 64'(bus.stall), 1);
         @(posedge clk);
         #1 check($sformatf("sat%0d stall_count", k), 64'(bus.stall_count), 64'hFFFF);
      end

      // Reset asserted during a stall cycle
      @(negedge clk);
      drive_id(0, 0, 2, 1);
      @(negedge clk);
      drive_id(2, 0, 5, 0);
      reset = 0;
      #1 check("rst-in-stall stall comb", 64'(bus.stall), 1);
      @(posedge clk);
      #1;
      check("rst-in-stall stall_count", 64'(bus.stall_count), 0);
      check("rst-in-stall ex_valid", 64'(bus.ex_valid), 0);
      check("rst-in-stall ex_rd", 64'(bus.ex_rd), 0);
      check("rst-in-stall ex_mem_read", 64'(bus.ex_mem_read), 0);
      @(negedge clk);
      reset = 1;
      #1 check("post-rst stall", 64'(bus.stall), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
